// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative M-extension multiply/divide unit for the EX stage.
// Multiplication is radix-2 shift-add and division is radix-2 restoring.
// Both iterate over unsigned operand magnitudes and fix the sign at the end.
// An accepted operation finishes 33 cycles after start.
// Divide-by-zero and signed overflow finish in one cycle.
//
// Build option: define R200_MULDIV_DIV_EN to include the DIV state, the
// divider datapath and the divide fast paths. Without it, every func3 >= 4
// returns 0 on the next cycle without stalling. Multiply behaviour is the
// same in both builds.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [4:0]  rdaddr,
    input  logic        flush,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  res_rdaddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef R200_MULDIV_DIV_EN
        DIV  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Iteration counter and operation context captured at accept.
    logic [4:0]  cnt;
    logic [2:0]  fn;
    logic [4:0]  rd_q;
    logic        neg_a;      // sign of the product / quotient
`ifdef R200_MULDIV_DIV_EN
    logic        neg_r;      // sign of the remainder (dividend sign)
`endif

    // Shared working register.
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [63:0] work;
    logic [31:0] opb;        // multiplicand or divisor magnitude

    // Input decode.
    logic        sgn1;
    logic        sgn2;
    logic        neg1;
    logic        neg2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        fast;
    logic [31:0] fast_res;
    logic        accept;
    logic        last;

    // One multiply step.
    logic [32:0] mul_sum;
    logic [63:0] mul_work;
    logic [63:0] mul_full;
    logic [31:0] mul_res;

`ifdef R200_MULDIV_DIV_EN
    // One divide step.
    logic [31:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_work;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] div_res;
`endif

    // Decode operand signedness and form the unsigned magnitudes.
    always_comb begin
        // Divide rows: only the even func3 codes (DIV, REM) are signed.
        // Multiply rows: op1 is signed except MULHU; op2 is signed only for MUL/MULH.
        sgn1 = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
        sgn2 = func3[2] ? ~func3[0] : ~func3[1];
        neg1 = sgn1 & op1[31];
        neg2 = sgn2 & op2[31];
        mag1 = neg1 ? (32'd0 - op1) : op1;
        mag2 = neg2 ? (32'd0 - op2) : op2;
    end

    // Detect the operations that finish without iterating, and their result.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        fast     = 1'b0;
        fast_res = 32'd0;
`ifdef R200_MULDIV_DIV_EN
        if (func3[2]) begin
            if (op2 == 32'd0) begin
                // Divide by zero: the quotient is all ones and the remainder is the dividend.
                fast     = 1'b1;
                fast_res = func3[1] ? op1 : 32'hFFFF_FFFF;
            end else if (!func3[0] && op1 == 32'h8000_0000 && op2 == 32'hFFFF_FFFF) begin
                // Signed overflow: the quotient wraps to the most negative value and the remainder is 0.
                fast     = 1'b1;
                fast_res = func3[1] ? 32'd0 : 32'h8000_0000;
            end
        end
`else
        // No divider in this build: every divide code completes at once with 0.
        fast     = func3[2];
        fast_res = 32'd0;
`endif
    end

    assign accept = (state == IDLE) && start && !flush;
    assign last   = (cnt == 5'd31);

    // Shift-add step: add the multiplicand when the multiplier LSB is set, then shift right.
    always_comb begin
        mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opb} : 33'd0);
        mul_work = {mul_sum, work[31:1]};
        mul_full = neg_a ? (64'd0 - mul_work) : mul_work;
        mul_res  = (fn == 3'd0) ? mul_full[31:0] : mul_full[63:32];
    end

`ifdef R200_MULDIV_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    always_comb begin
        // The shifted remainder is 33 bits wide. If its MSB (work[63]) is set, it
        // always exceeds the divisor. The 32-bit wrapped difference is then still exact.
        div_shift = {work[62:32], work[31]};
        div_ge    = work[63] | (div_shift >= opb);
        div_rem   = div_ge ? (div_shift - opb) : div_shift;
        div_work  = {div_rem, work[30:0], div_ge};
        div_q     = div_work[31:0];
        div_r     = div_work[63:32];
        div_res   = fn[1] ? (neg_r ? (32'd0 - div_r) : div_r)
                          : (neg_a ? (32'd0 - div_q) : div_q);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; flush aborts any operation in progress.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fast) begin
                        state_next = DONE;
`ifdef R200_MULDIV_DIV_EN
                    end else if (func3[2]) begin
                        state_next = DIV;
`endif
                    end else begin
                        state_next = MUL;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
`ifdef R200_MULDIV_DIV_EN
            DIV: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: done marks the result cycle; stall covers accept through the last iteration.
    always_comb begin
        done      = (state == DONE);
        stall_req = ((state == IDLE) && start && !fast) || (state == MUL);
`ifdef R200_MULDIV_DIV_EN
        if (state == DIV) begin
            stall_req = 1'b1;
        end
`endif
    end

    // Operand capture and iteration of the shared working register.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath registers carry no reset; the FSM ignores them until an accept loads them.
        if (accept) begin
            fn    <= func3;
            rd_q  <= rdaddr;
            neg_a <= neg1 ^ neg2;
`ifdef R200_MULDIV_DIV_EN
            neg_r <= neg1;
`endif
            opb   <= mag2;
            work  <= {32'd0, mag1};
        end else if (state == MUL) begin
            work  <= mul_work;
`ifdef R200_MULDIV_DIV_EN
        end else if (state == DIV) begin
            work  <= div_work;
`endif
        end
    end

    // Iteration counter and result registers; results hold until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 5'd0;
            result     <= 32'd0;
            res_rdaddr <= 5'd0;
        end else begin
            if (accept) begin
                cnt <= 5'd0;
            end else if (state != IDLE && state != DONE) begin
                cnt <= cnt + 5'd1;
            end

            if (accept && fast) begin
                result     <= fast_res;
                res_rdaddr <= rdaddr;
            end else if (state == MUL && last && !flush) begin
                result     <= mul_res;
                res_rdaddr <= rd_q;
`ifdef R200_MULDIV_DIV_EN
            end else if (state == DIV && last && !flush) begin
                result     <= div_res;
                res_rdaddr <= rd_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized self-checking bench for ex_muldiv.
// Expected results come from a plain-arithmetic model of the M extension.
// The bench follows R200_MULDIV_DIV_EN so that it matches the build under test.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rdaddr;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic [4:0]  res_rdaddr;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] hold_res;
    logic [4:0]  hold_rd;

    ex_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .func3      (func3),
        .op1        (op1),
        .op2        (op2),
        .rdaddr     (rdaddr),
        .flush      (flush),
        .stall_req  (stall_req),
        .done       (done),
        .result     (result),
        .res_rdaddr (res_rdaddr)
    );

    always #5 clk = ~clk;

    // Reference result from M-extension arithmetic on 64-bit integers.
    function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (f)
            3'd0: p = sa * sb;
            3'd1: p = sa * sb;
            3'd2: p = sa * longint'({32'd0, b});
            3'd3: p = {32'd0, a} * {32'd0, b};
            default: p = 64'd0;
        endcase
        if (f == 3'd0) return p[31:0];
        if (f < 3'd4) return p[63:32];
`ifdef R200_MULDIV_DIV_EN
        case (f)
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
`else
        return 32'd0;
`endif
    endfunction

    // Cycles from start to done.
    function automatic int model_latency(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
`ifdef R200_MULDIV_DIV_EN
        if (f >= 3'd4 && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return (f >= 3'd4) ? 1 : 33;
`endif
    endfunction

    // Operand generator biased toward corner values.
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, then scramble inputs and raise stray starts while busy.
    // Checks the stall window, that outputs hold, and the done cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        logic [31:0] exp;
        int          lat;
        exp = model_result(f, a, b);
        lat = model_latency(f, a, b);
        @(negedge clk);
        start = 1'b1; func3 = f; op1 = a; op2 = b; rdaddr = rd;
        #1;
        nvec++;
        if (stall_req !== (lat != 1)) begin
            nerr++;
            $display("FAIL stall_at_start f=%0d a=%h b=%h: got %b want %b", f, a, b, stall_req, lat != 1);
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start  = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            func3  = 3'($urandom);
            op1    = $urandom;
            op2    = $urandom;
            rdaddr = 5'($urandom);
            #1;
            if (k < lat) begin
                nvec++;
                if (done !== 1'b0 || stall_req !== 1'b1) begin
                    nerr++;
                    $display("FAIL busy f=%0d cyc=%0d: got done=%b stall=%b want done=0 stall=1", f, k, done, stall_req);
                end
                nvec++;
                if (result !== hold_res || res_rdaddr !== hold_rd) begin
                    nerr++;
                    $display("FAIL hold f=%0d cyc=%0d: got %h/%0d want %h/%0d", f, k, result, res_rdaddr, hold_res, hold_rd);
                end
            end else begin
                nvec++;
                if (done !== 1'b1 || stall_req !== 1'b0) begin
                    nerr++;
                    $display("FAIL done_cycle f=%0d cyc=%0d: got done=%b stall=%b want done=1 stall=0", f, k, done, stall_req);
                end
                nvec++;
                if (result !== exp) begin
                    nerr++;
                    $display("FAIL result f=%0d a=%h b=%h: got %h want %h", f, a, b, result, exp);
                end
                nvec++;
                if (res_rdaddr !== rd) begin
                    nerr++;
                    $display("FAIL res_rdaddr f=%0d: got %0d want %0d", f, res_rdaddr, rd);
                end
                hold_res = exp;
                hold_rd  = rd;
            end
        end
        start = 1'b0;
    endtask

    // Reset clears the outputs and leaves the unit idle.
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        nvec++;
        if (done !== 1'b0 || result !== 32'd0 || res_rdaddr !== 5'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got done=%b result=%h rd=%0d want 0/0/0", done, result, res_rdaddr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if (done !== 1'b0 || stall_req !== 1'b0) begin
            nerr++;
            $display("FAIL reset_idle: got done=%b stall=%b want 0/0", done, stall_req);
        end
        hold_res = 32'd0;
        hold_rd  = 5'd0;
    endtask

    task automatic test_mul_directed();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5);
    endtask

    task automatic test_div_directed();
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op(3'd5, 32'd100, 32'd7, 5'd8);
        run_op(3'd7, 32'd100, 32'd7, 5'd9);
        run_op(3'd5, 32'd1234, 32'd0, 5'd10);
        run_op(3'd6, 32'hDEAD_BEEF, 32'd0, 5'd11);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op(3'd7, 32'hFFFF_FFFF, 32'h8000_0001, 5'd14);
    endtask

    task automatic test_random();
        repeat (30) run_op(3'($urandom_range(0, 3)), pick(), pick(), 5'($urandom));
        repeat (30) run_op(3'($urandom_range(4, 7)), pick(), pick(), 5'($urandom));
    endtask

    // Alternate fast and iterative ops with no idle gap between them.
    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op(3'd5, $urandom, 32'd0, 5'($urandom));
            run_op(3'd0, $urandom, $urandom, 5'($urandom));
            run_op(3'd7, $urandom, 32'd0, 5'($urandom));
        end
    endtask

    // Flush aborts a multiply and also blocks a start that arrives in the same cycle.
    task automatic test_flush();
        @(negedge clk);
        start = 1'b1; func3 = 3'd0; op1 = $urandom; op2 = $urandom; rdaddr = 5'd21;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (k == 10);
            #1;
            nvec++;
            if (done !== 1'b0 || stall_req !== (k <= 10)) begin
                nerr++;
                $display("FAIL flush_abort cyc=%0d: got done=%b stall=%b want done=0 stall=%b", k, done, stall_req, k <= 10);
            end
            nvec++;
            if (result !== hold_res || res_rdaddr !== hold_rd) begin
                nerr++;
                $display("FAIL flush_hold cyc=%0d: got %h/%0d want %h/%0d", k, result, res_rdaddr, hold_res, hold_rd);
            end
        end
        run_op(3'd0, $urandom, $urandom, 5'd22);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; func3 = 3'd0; op1 = 32'd3; op2 = 32'd5; rdaddr = 5'd23;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        nvec++;
        if (stall_req !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL flush_start_mul: got stall=%b done=%b want 0/0", stall_req, done);
        end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; func3 = 3'd5; op1 = 32'd9; op2 = 32'd0; rdaddr = 5'd24;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        nvec++;
        if (done !== 1'b0 || result !== hold_res || res_rdaddr !== hold_rd) begin
            nerr++;
            $display("FAIL flush_start_fast: got done=%b %h/%0d want 0 %h/%0d", done, result, res_rdaddr, hold_res, hold_rd);
        end
    endtask

    // Reset lands mid-operation while start stays high.
    task automatic test_rst_mid();
        logic [2:0] f;
`ifdef R200_MULDIV_DIV_EN
        f = 3'd4;
`else
        f = 3'd0;
`endif
        @(negedge clk);
        start = 1'b1; func3 = f; op1 = 32'd100; op2 = 32'd7; rdaddr = 5'd17;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rst = (k >= 5);
            #1;
            if (k < 5) begin
                nvec++;
                if (done !== 1'b0 || stall_req !== 1'b1) begin
                    nerr++;
                    $display("FAIL rst_pre cyc=%0d: got done=%b stall=%b want 0/1", k, done, stall_req);
                end
            end
        end
        #1;
        nvec++;
        if (done !== 1'b0 || result !== 32'd0 || res_rdaddr !== 5'd0) begin
            nerr++;
            $display("FAIL rst_mid_outputs: got done=%b %h/%0d want 0 0/0", done, result, res_rdaddr);
        end
        hold_res = 32'd0;
        hold_rd  = 5'd0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        nvec++;
        if (done !== 1'b0 || stall_req !== 1'b0 || result !== 32'd0) begin
            nerr++;
            $display("FAIL rst_release: got done=%b stall=%b result=%h want 0/0/0", done, stall_req, result);
        end
        run_op(f, 32'd100, 32'd7, 5'd18);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'd0;
        op1 = 32'd0; op2 = 32'd0; rdaddr = 5'd0;
        hold_res = 32'd0; hold_rd = 5'd0;
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
